l2_way_data_array: RTL

Parametrised, multi-way successor to the single-way L2 data array. Stores `num_ways × 2**s_index` lines of `8*2**s_offset` bits, supports byte-masked writes to one way per cycle, and serves one-way reads with 1- or 2-cycle configurable latency and a valid strobe. After every reset it clears its contents with a self-timed sweep. It sits under the L2 cache datapath, beside the tag/valid arrays, and is driven by the L2 controller.

---
 rtl/l2_way_data_array.sv | 134 +++++++++++++
 1 files changed

// File: rtl/l2_way_data_array.sv
// Multi-way L2 data array: byte-masked writes to one way per cycle, one-way
// reads with 1- or 2-cycle latency and a valid strobe, and a self-timed
// clear sweep after every reset.
module l2_way_data_array #(
  parameter int s_offset     = 5,
  parameter int s_index      = 3,
  parameter int num_ways     = 4,
  parameter int read_latency = 1,
  localparam int s_mask   = 2**s_offset,
  localparam int s_line   = 8*s_mask,
  localparam int num_sets = 2**s_index,
  localparam int s_way    = $clog2(num_ways)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic              read,
  input  logic [s_index-1:0] rindex,
  input  logic [s_way-1:0]  rway,
  input  logic [s_mask-1:0] write_en,
  input  logic [s_index-1:0] windex,
  input  logic [s_way-1:0]  wway,
  input  logic [s_line-1:0] datain,
  output logic [s_line-1:0] dataout,
  output logic              rvalid
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [s_index-1:0]  cnt_q, cnt_d;
  logic                ready;

  logic [s_line-1:0]   wbits;
  logic [num_ways-1:0][s_line-1:0] row_rd;
  logic [s_line-1:0]   rd_old;
  logic [s_line-1:0]   rd_line;
  logic                collide;

  logic                s1_valid_q;
  logic [s_line-1:0]   s1_data_q;

  // State and sweep counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep one set per cycle, leave INIT after the last set
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == s_index'(num_sets-1)) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  assign ready     = (state_q == ST_READY);
  assign init_busy = ~ready;

  // Byte mask expanded to a bit mask
  for (genvar b = 0; b < s_mask; b++) begin : g_wbits
    assign wbits[8*b +: 8] = {8{write_en[b]}};
  end

  // One storage row per way; contents are cleared only by the sweep
  for (genvar w = 0; w < num_ways; w++) begin : g_way
    logic [s_line-1:0] mem_q [num_sets];

    // Sweep clear in INIT, masked write in READY
    always_ff @(posedge clk) begin
      if (!ready) begin
        mem_q[cnt_q] <= '0;
      end else if ((|write_en) && (wway == s_way'(w))) begin
        mem_q[windex] <= (mem_q[windex] & ~wbits) | (datain & wbits);
      end
    end

    assign row_rd[w] = mem_q[rindex];
  end

  assign rd_old  = row_rd[rway];
  assign collide = (rway == wway) && (rindex == windex);

  // Same-cycle bypass: masked bytes of a colliding write replace the old line
  always_comb begin
    rd_line = rd_old;
    if (collide) rd_line = (rd_old & ~wbits) | (datain & wbits);
  end

  // Read stage 1: capture the selected line when a read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= ready & read;
      if (ready && read) s1_data_q <= rd_line;
    end
  end

  if (read_latency == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [s_line-1:0] s2_data_q;

    // Read stage 2: forward stage 1, holding data between reads
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rvalid  = s2_valid_q;
    assign dataout = s2_data_q;
  end else begin : g_lat1
    assign rvalid  = s1_valid_q;
    assign dataout = s1_data_q;
  end

endmodule
